exmem_stage: RTL and testbench

Parametrised EX/MEM pipeline stage register with valid/ready flow control, flush and bubble insertion. It captures execute-stage results (instruction, PC, ALU result, store data, control bits, destination register) and presents them to the memory stage. Unlike a plain always-load register, it supports back-pressure from MEM, squashes wrong-path instructions on flush and neutralises control bits of bubbles. An optional 2-entry skid buffer decouples `in_ready` from `out_ready`.

---
 rtl/exmem_stage.sv | 149 ++++++++++++++
 tb/tb_exmem_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage register with valid/ready flow control, flush and bubble insertion.
// Define PIPE_SKID_EN to build the 2-entry skid buffer with a registered in_ready.
module exmem_stage #(
  parameter int              XLEN     = 32,
  parameter int              CTRL_W   = 4,
  parameter int              DST_W    = 5,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   inst_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DST_W-1:0]  dst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   inst_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   rs2_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DST_W-1:0]  dst_out
);

  typedef struct packed {
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rs2;
    logic [CTRL_W-1:0] ctrl;
    logic [DST_W-1:0]  dst;
  } entry_t;

  entry_t in_ent;
  entry_t main_q, main_d;
  logic   in_fire, out_fire;

  assign in_ent = {inst_in, pc_in, alu_in, rs2_in, ctrl_in, dst_in};

`ifdef PIPE_SKID_EN
  // state   | meaning
  // S_EMPTY | nothing held, bubble on the outputs
  // S_ONE   | main register holds the entry shown to MEM
  // S_TWO   | main shown, skid holds the next entry; in_ready low
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state_q, state_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_d  = in_ent;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_ent;
          end else if (in_fire) begin
            skid_d  = in_ent;
            state_d = S_TWO;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // Registered so in_ready never depends on this cycle's out_ready.
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  logic valid_q, valid_d;

  assign out_valid = valid_q;
  assign in_ready  = !valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    main_d  = main_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_fire) begin
      main_d  = in_ent;
      valid_d = 1'b1;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end
`endif

  // Flush leaves the payload untouched; only validity is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) main_q <= '0;
    else        main_q <= main_d;
  end

  assign inst_out = out_valid ? main_q.inst : NOP_INST;
  assign pc_out   = main_q.pc;
  assign alu_out  = main_q.alu;
  assign rs2_out  = main_q.rs2;
  assign ctrl_out = out_valid ? main_q.ctrl : '0;
  assign dst_out  = out_valid ? main_q.dst  : '0;

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed scenarios plus randomized traffic
// against a FIFO reference model (capacity 2 with PIPE_SKID_EN, else 1).
module tb_exmem_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [4:0]  dst;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] inst_out, pc_out, alu_out, rs2_out;
  logic [3:0]  ctrl_out;
  logic [4:0]  dst_out;
  ent_t cur_in = '0;

  ent_t q[$];
  ent_t last = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  exmem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(cur_in.inst), .pc_in(cur_in.pc), .alu_in(cur_in.alu), .rs2_in(cur_in.rs2),
    .ctrl_in(cur_in.ctrl), .dst_in(cur_in.dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst_out(inst_out), .pc_out(pc_out), .alu_out(alu_out), .rs2_out(rs2_out),
    .ctrl_out(ctrl_out), .dst_out(dst_out)
  );

  function automatic logic exp_ready();
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.inst = $urandom;
    e.pc   = $urandom;
    e.alu  = $urandom;
    e.rs2  = $urandom;
    e.ctrl = 4'($urandom);
    e.dst  = 5'($urandom);
    return e;
  endfunction

  // Advance one clock and update the FIFO model with the transfers at that edge.
  task automatic tick();
    logic ifire, ofire;
    ifire = in_valid && exp_ready();
    ofire = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      last = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(cur_in);
    end
    if (q.size() > 0) last = q[0];
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cur_in = rand_ent();
    tick(); tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_out, NOP); end
    checks++; if ({pc_out, alu_out, rs2_out} !== 96'd0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", pc_out, alu_out, rs2_out); end
    checks++; if ({ctrl_out, dst_out} !== 9'd0) begin errors++; $display("FAIL reset_ctrl got %h %h exp 0", ctrl_out, dst_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [3:0] sent_ctrl;
    idle(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_pre_valid got %0b exp 0", out_valid); end
    for (int k = 1; k <= 3; k++) begin
      cur_in = rand_ent(); cur_in.alu = k; sent_ctrl = cur_in.ctrl;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || alu_out !== 32'(k)) begin errors++; $display("FAIL stream_alu got v=%0b %0d exp v=1 %0d", out_valid, alu_out, k); end
      checks++; if (ctrl_out !== sent_ctrl) begin errors++; $display("FAIL stream_ctrl got %h exp %h", ctrl_out, sent_ctrl); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int seq [3] = '{10, 11, 12};
    int rx[$];
    int idx = 0, cyc = 0;
    logic fire;
    idle(2);
    while (rx.size() < 3 && cyc < 20) begin
      cur_in = rand_ent(); cur_in.alu = seq[idx < 3 ? idx : 2];
      in_valid = (idx < 3);
      out_ready = (cyc >= 2);
      fire = in_valid && exp_ready();
      if (out_valid && out_ready) rx.push_back(int'(alu_out));
      tick();
      if (fire) idx++;
      if (cyc < 2) begin
        checks++; if (alu_out !== 32'd10 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_hold got v=%0b %0d exp v=1 10", out_valid, alu_out); end
      end
      if (cyc == 1) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
      end
      cyc++;
    end
    checks++;
    if (rx.size() != 3 || rx[0] != 10 || rx[1] != 11 || rx[2] != 12) begin
      errors++; $display("FAIL bp_order got %p exp 10 11 12", rx);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush_full();
    idle(2);
    out_ready = 1'b0; in_valid = 1'b1;
    cur_in = rand_ent(); cur_in.alu = 20; tick();
    cur_in = rand_ent(); cur_in.alu = 21; tick();
    flush = 1'b1; cur_in = rand_ent(); cur_in.alu = 22; tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || inst_out !== NOP) begin errors++; $display("FAIL flush_bubble got v=%0b inst=%h exp v=0 %h", out_valid, inst_out, NOP); end
    checks++; if (ctrl_out !== 4'd0 || dst_out !== 5'd0) begin errors++; $display("FAIL flush_ctrl got %h %h exp 0", ctrl_out, dst_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b exp 1", in_ready); end
    checks++; if (alu_out !== 32'd20) begin errors++; $display("FAIL flush_hold_alu got %0d exp 20", alu_out); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_replay got v=%0b alu=%0d exp v=0", out_valid, alu_out); end
    end
  endtask

  task automatic test_bubble();
    idle(2);
    in_valid = 1'b0; cur_in = rand_ent(); cur_in.ctrl = 4'b0011; cur_in.dst = 5'd7;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || ctrl_out !== 4'd0 || dst_out !== 5'd0 || inst_out !== NOP) begin
      errors++; $display("FAIL bubble got v=%0b ctrl=%h dst=%h inst=%h exp 0 0 0 %h", out_valid, ctrl_out, dst_out, inst_out, NOP);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle(2);
    out_ready = 1'b0; in_valid = 1'b1;
    cur_in = rand_ent(); tick();
    cur_in = rand_ent(); tick();
    in_valid = 1'b0; rst_n = 1'b0; tick();
    checks++; if (out_valid !== 1'b0 || inst_out !== NOP || {pc_out, alu_out, rs2_out} !== 96'd0 || {ctrl_out, dst_out} !== 9'd0) begin
      errors++; $display("FAIL rst_stall_out got v=%0b inst=%h pc=%h alu=%h rs2=%h exp reset values", out_valid, inst_out, pc_out, alu_out, rs2_out);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_in_ready got %0b exp 1", in_ready); end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_stale got v=%0b exp 0", out_valid); end
    end
  endtask

  task automatic test_random();
    idle(2);
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      cur_in    = rand_ent();
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_in_ready cyc %0d got %0b exp %0b", c, in_ready, exp_ready()); end
      tick();
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", c, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if ({inst_out, pc_out, alu_out, rs2_out, ctrl_out, dst_out} !== q[0]) begin
          errors++; $display("FAIL rand_payload cyc %0d got alu=%h pc=%h exp alu=%h pc=%h", c, alu_out, pc_out, q[0].alu, q[0].pc);
        end
      end else begin
        checks++; if (inst_out !== NOP || ctrl_out !== 4'd0 || dst_out !== 5'd0 || {pc_out, alu_out, rs2_out} !== {last.pc, last.alu, last.rs2}) begin
          errors++; $display("FAIL rand_bubble cyc %0d got inst=%h ctrl=%h alu=%h exp %h 0 %h", c, inst_out, ctrl_out, alu_out, NOP, last.alu);
        end
      end
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_bubble();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
